// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Owner encoding steers each registered read response back to its requester.
package imem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_FETCH   = 2'd1,
        OWN_LOAD_RD = 2'd2,
        OWN_LOAD_WR = 2'd3
    } owner_e;

    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-port signals of the instruction-memory arbiter.
// Handshake: a requester holds req (and its address/data) until it sees gnt in the
// same cycle; a granted read returns rvalid for exactly one cycle on the next cycle.
interface imem_arbiter_if;
    import imem_arbiter_pkg::*;

    logic              f_req;
    logic [WORD_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [WORD_W-1:0] f_rdata;

    logic              l_req;
    logic              l_we;
    logic [WORD_W-1:0] l_addr;
    logic [WORD_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [WORD_W-1:0] l_rdata;
    logic              l_err;

    logic [WORD_W-1:0] m_addr;
    logic              m_we;
    logic [WORD_W-1:0] m_wdata;
    logic [WORD_W-1:0] m_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, l_err,
               m_addr, m_we, m_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, l_err,
               m_addr, m_we, m_wdata
    );

endinterface

// File: rtl/imem_arb_burst_ctr.sv
// Saturating count of consecutive loader grants taken while fetch is waiting.
// Clear has priority over increment; at_max hands the next contended slot to fetch.
module imem_arb_burst_ctr #(
    parameter  int MAX   = 4,
    localparam int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    assign at_max = (cnt == CNT_W'(MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter: loader-priority with bounded bursts, 1-cycle reads.
// Define IMEM_ARB_STATS_EN to add the stat_fetch_stall / stat_load_cnt counters.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter  int DEPTH          = 256,
    parameter  int MAX_LOAD_BURST = 4,
    localparam int CNT_W          = $clog2(MAX_LOAD_BURST + 1)
) (
    input  logic             clk,
    input  logic             reset,
    imem_arbiter_if.slave    bus,
    output owner_e           dbg_owner,
    output logic [CNT_W-1:0] dbg_burst_cnt
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [31:0]      stat_fetch_stall,
    output logic [31:0]      stat_load_cnt
`endif
);

    logic              f_gnt;
    logic              l_gnt;
    logic              f_in_range;
    logic              l_in_range;
    logic              at_max;
    logic              l_err_q;
    logic [CNT_W-1:0]  burst_cnt;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] m_addr_q;
    logic [WORD_W-1:0] f_rdata_q;
    logic [WORD_W-1:0] l_rdata_q;
    owner_e            owner_q;
    owner_e            owner_d;

    assign f_in_range = (bus.f_addr < WORD_W'(DEPTH));
    assign l_in_range = (bus.l_addr < WORD_W'(DEPTH));

    // Grants are gated by reset so nothing reaches memory while held in reset.
    always_comb begin
        l_gnt = 1'b0;
        f_gnt = 1'b0;
        if (reset) begin
            if (bus.l_req && !(bus.f_req && at_max)) begin
                l_gnt = 1'b1;
            end else if (bus.f_req) begin
                f_gnt = 1'b1;
            end
        end
    end

    imem_arb_burst_ctr #(
        .MAX (MAX_LOAD_BURST)
    ) u_burst_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (f_gnt | ~bus.f_req),
        .inc    (l_gnt & bus.f_req),
        .cnt    (burst_cnt),
        .at_max (at_max)
    );

    always_comb begin
        mem_addr = m_addr_q;
        if (l_gnt) begin
            mem_addr = bus.l_addr;
        end else if (f_gnt) begin
            mem_addr = bus.f_addr;
        end
    end

    assign bus.m_addr  = mem_addr;
    assign bus.m_we    = l_gnt & bus.l_we & l_in_range;
    assign bus.m_wdata = l_gnt ? bus.l_wdata : '0;

    // Owner FSM: next state is simply whoever was granted this cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (f_gnt) begin
            owner_d = OWN_FETCH;
        end else if (l_gnt) begin
            owner_d = bus.l_we ? OWN_LOAD_WR : OWN_LOAD_RD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Out-of-range reads return zero instead of whatever the memory drives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_addr_q  <= '0;
            f_rdata_q <= '0;
            l_rdata_q <= '0;
            l_err_q   <= 1'b0;
        end else begin
            m_addr_q <= mem_addr;
            l_err_q  <= l_gnt & ~l_in_range;
            if (f_gnt) begin
                f_rdata_q <= f_in_range ? bus.m_rdata : '0;
            end
            if (l_gnt && !bus.l_we) begin
                l_rdata_q <= l_in_range ? bus.m_rdata : '0;
            end
        end
    end

    assign bus.f_gnt    = f_gnt;
    assign bus.l_gnt    = l_gnt;
    assign bus.f_rvalid = (owner_q == OWN_FETCH);
    assign bus.l_rvalid = (owner_q == OWN_LOAD_RD);
    assign bus.f_rdata  = f_rdata_q;
    assign bus.l_rdata  = l_rdata_q;
    assign bus.l_err    = l_err_q;

    assign dbg_owner     = owner_q;
    assign dbg_burst_cnt = burst_cnt;

`ifdef IMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetch_stall <= '0;
            stat_load_cnt    <= '0;
        end else begin
            if (bus.f_req && !f_gnt) begin
                stat_fetch_stall <= stat_fetch_stall + 32'd1;
            end
            if (l_gnt) begin
                stat_load_cnt <= stat_load_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: behavioural model plus per-cycle compare process,
// with hand-computed literal checks for reset, write/fetch, starvation, range and reset cases.
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  localparam int DEPTH     = 256;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset;

  imem_arbiter_if bus ();
  owner_e     dbg_owner;
  logic [2:0] dbg_burst_cnt;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stat_fetch_stall;
  logic [31:0] stat_load_cnt;
`endif

  imem_arbiter #(
    .DEPTH          (DEPTH),
    .MAX_LOAD_BURST (MAX_BURST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .dbg_owner     (dbg_owner),
    .dbg_burst_cnt (dbg_burst_cnt)
`ifdef IMEM_ARB_STATS_EN
    ,
    .stat_fetch_stall (stat_fetch_stall),
    .stat_load_cnt    (stat_load_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory environment ----------------
  logic [31:0] mem [DEPTH];
  int          we_cnt = 0;

  assign bus.m_rdata = (bus.m_addr < DEPTH) ? mem[bus.m_addr[7:0]] : 32'hBAD0_BAD0;

  initial forever begin
    @(posedge clk);
    if (bus.m_we === 1'b1) begin
      mem[bus.m_addr[7:0]] <= bus.m_wdata;
      we_cnt++;
    end
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // ---------------- counters and check helpers ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Loader wins contention until it has taken MAX_BURST slots in a row while fetch waits.
  logic [31:0] ref_mem [DEPTH];
  int          streak;
  logic        m_l_pend, m_l_err;
  logic [31:0] m_l_data, m_last_addr;
  logic [31:0] exp_q [$];
  logic        p_l, p_f;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      streak      = 0;
      m_l_pend    = 1'b0;
      m_l_err     = 1'b0;
      m_l_data    = '0;
      m_last_addr = '0;
      exp_q.delete();
    end else begin
      p_l = bus.l_req && !(bus.f_req && streak >= MAX_BURST);
      p_f = bus.f_req && !p_l;
      m_l_pend = p_l && !bus.l_we;
      m_l_err  = p_l && (bus.l_addr >= DEPTH);
      if (p_l && !bus.l_we)
        m_l_data = (bus.l_addr < DEPTH) ? ref_mem[bus.l_addr[7:0]] : 32'h0;
      if (p_f)
        exp_q.push_back((bus.f_addr < DEPTH) ? ref_mem[bus.f_addr[7:0]] : 32'h0);
      if (p_l) m_last_addr = bus.l_addr;
      else if (p_f) m_last_addr = bus.f_addr;
      if (p_l && bus.l_we && bus.l_addr < DEPTH) ref_mem[bus.l_addr[7:0]] = bus.l_wdata;
      if (p_f || !bus.f_req) streak = 0;
      else if (p_l && streak < MAX_BURST) streak = streak + 1;
    end
  end

  // ---------------- compare process ----------------
  logic        e_l, e_f;
  logic [31:0] e_addr, f_hold, e_d;

  initial begin
    f_hold = '0;
    forever begin
      @(negedge clk);
      e_l = reset && bus.l_req && !(bus.f_req && streak >= MAX_BURST);
      e_f = reset && bus.f_req && !e_l;
      check1("f_gnt", bus.f_gnt, e_f);
      check1("l_gnt", bus.l_gnt, e_l);
      check1("gnt_exclusive", bus.f_gnt & bus.l_gnt, 1'b0);
      check1("m_we", bus.m_we, e_l && bus.l_we && (bus.l_addr < DEPTH));
      e_addr = e_l ? bus.l_addr : (e_f ? bus.f_addr : m_last_addr);
      check("m_addr", bus.m_addr, e_addr);
      if (e_l) check("m_wdata", bus.m_wdata, bus.l_wdata);
      check("burst_cnt", 32'(dbg_burst_cnt), 32'(streak));
      if (!reset) f_hold = '0;
      if (exp_q.size() > 0) begin
        e_d = exp_q.pop_front();
        check1("f_rvalid", bus.f_rvalid, 1'b1);
        check("f_rdata", bus.f_rdata, e_d);
        f_hold = e_d;
      end else begin
        check1("f_rvalid", bus.f_rvalid, 1'b0);
        check("f_rdata_hold", bus.f_rdata, f_hold);
      end
      check1("l_rvalid", bus.l_rvalid, m_l_pend);
      check("l_rdata", bus.l_rdata, m_l_data);
      check1("l_err", bus.l_err, m_l_err);
    end
  end

  // ---------------- driver ----------------
  task automatic set_in(input logic fr, input logic [31:0] fa, input logic lr,
                        input logic lw, input logic [31:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    bus.f_req   = fr;
    bus.f_addr  = fa;
    bus.l_req   = lr;
    bus.l_we    = lw;
    bus.l_addr  = la;
    bus.l_wdata = ld;
    @(negedge clk);
  endtask

  task automatic idle();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int    we_base;
  string pat;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stall_base, load_base;
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    reset       = 1'b0;
    bus.f_req   = 1'b1;
    bus.f_addr  = 32'd3;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = 32'd0;
    bus.l_wdata = 32'd0;

    // Reset holds everything at zero even with a fetch pending.
    @(negedge clk);
    @(negedge clk);
    check1("rst_f_gnt", bus.f_gnt, 1'b0);
    check1("rst_f_rvalid", bus.f_rvalid, 1'b0);
    check1("rst_m_we", bus.m_we, 1'b0);
    check("rst_m_addr", bus.m_addr, 32'd0);
    check("rst_f_rdata", bus.f_rdata, 32'd0);
    check("rst_owner", 32'(dbg_owner), 32'(OWN_NONE));

    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check1("rel_f_gnt", bus.f_gnt, 1'b1);
    check("rel_m_addr", bus.m_addr, 32'd3);
    idle();
    check1("rel_f_rvalid", bus.f_rvalid, 1'b1);
    check("rel_f_rdata", bus.f_rdata, init_word(3));

    // Loader write then fetch of the same word.
    we_base = we_cnt;
    set_in(1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
    check1("wr_m_we", bus.m_we, 1'b1);
    check("wr_m_addr", bus.m_addr, 32'd5);
    set_in(1'b1, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0);
    check1("rd_f_gnt", bus.f_gnt, 1'b1);
    check1("rd_m_we", bus.m_we, 1'b0);
    idle();
    check1("rd_f_rvalid", bus.f_rvalid, 1'b1);
    check("rd_f_rdata", bus.f_rdata, 32'hDEADBEEF);
    check("wr_pulses", 32'(we_cnt - we_base), 32'd1);

    // Starvation guard under continuous contention.
`ifdef IMEM_ARB_STATS_EN
    stall_base = stat_fetch_stall;
    load_base  = stat_load_cnt;
`endif
    pat = "";
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'd8, 1'b1, 1'b0, 32'd20, 32'd0);
      if (bus.l_gnt && !bus.f_gnt) pat = {pat, "L"};
      else if (bus.f_gnt && !bus.l_gnt) pat = {pat, "F"};
      else pat = {pat, "x"};
    end
    n_total++;
    if (pat == "LLLLFLLLLF") n_pass++;
    else $display("FAIL grant_pattern: got %s expected LLLLFLLLLF", pat);
    idle();
`ifdef IMEM_ARB_STATS_EN
    check("stat_load_cnt", stat_load_cnt - load_base, 32'd8);
    check("stat_fetch_stall", stat_fetch_stall - stall_base, 32'd8);
`endif

    // Out-of-range loader read and write, then out-of-range fetch.
    set_in(1'b0, 32'd0, 1'b1, 1'b0, 32'd7, 32'd0);
    set_in(1'b0, 32'd0, 1'b1, 1'b0, 32'd256, 32'd0);
    check1("oor_rd_m_we", bus.m_we, 1'b0);
    check("inr_l_rdata", bus.l_rdata, init_word(7));
    idle();
    check1("oor_rd_l_err", bus.l_err, 1'b1);
    check1("oor_rd_l_rvalid", bus.l_rvalid, 1'b1);
    check("oor_rd_l_rdata", bus.l_rdata, 32'd0);
    we_base = we_cnt;
    set_in(1'b0, 32'd0, 1'b1, 1'b1, 32'd300, 32'h1234_5678);
    check1("oor_wr_m_we", bus.m_we, 1'b0);
    idle();
    check1("oor_wr_l_err", bus.l_err, 1'b1);
    check1("oor_wr_l_rvalid", bus.l_rvalid, 1'b0);
    check("oor_wr_pulses", 32'(we_cnt - we_base), 32'd0);
    set_in(1'b1, 32'd1000, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    check1("oor_f_rvalid", bus.f_rvalid, 1'b1);
    check("oor_f_rdata", bus.f_rdata, 32'd0);
    check1("oor_f_no_err", bus.l_err, 1'b0);

    // Reset right after a loader read grant drops its response.
    set_in(1'b1, 32'd8, 1'b1, 1'b0, 32'd30, 32'd0);
    set_in(1'b1, 32'd8, 1'b1, 1'b0, 32'd31, 32'd0);
    check("pre_rst_burst", 32'(dbg_burst_cnt), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check1("mid_rst_l_rvalid", bus.l_rvalid, 1'b0);
    check("mid_rst_burst", 32'(dbg_burst_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check1("post_rst_l_gnt", bus.l_gnt, 1'b1);
    check1("post_rst_f_gnt", bus.f_gnt, 1'b0);
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
